// File: rtl/plot_receiver.sv
// Plot-command receiver: queues {x,y,colour} plots in a small FIFO and issues them as
// frame-buffer writes, giving display scan reads priority. Optional clipping: PLOT_RECEIVER_CLIP_EN.
module plot_receiver #(
    parameter int FIFO_DEPTH = 4,
    parameter int H_RES      = 160,
    parameter int V_RES      = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [2:0]  colour,
    input  logic        plot,
    output logic        ready,
    input  logic        scan_req,
    input  logic [14:0] scan_addr,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [7:0]  drop_count,
    output logic        busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [14:0] ROW_STRIDE = 15'(H_RES);

    // Encoding chosen so each strobe is exactly one state flop bit.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        READ  = 2'b10
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0] fifo_x [FIFO_DEPTH];
    logic [7:0] fifo_y [FIFO_DEPTH];
    logic [2:0] fifo_c [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic        in_range;
    logic        push;
    logic        pop;
    logic        reject;
    logic [14:0] head_addr;

`ifdef PLOT_RECEIVER_CLIP_EN
    localparam logic [8:0] X_LIMIT = 9'(H_RES);
    localparam logic [8:0] Y_LIMIT = 9'(V_RES);

    assign in_range = ({1'b0, x} < X_LIMIT) && ({1'b0, y} < Y_LIMIT);
`else
    assign in_range = 1'b1;
`endif

    assign ready  = (count != FULL_COUNT);
    assign push   = plot && ready && in_range;
    assign reject = plot && !(ready && in_range);
    assign pop    = (next_state == WRITE);

    // Address wraps modulo 2^15 on purpose for out-of-range coordinates.
    assign head_addr = 15'(fifo_y[rd_ptr]) * ROW_STRIDE + 15'(fifo_x[rd_ptr]);

    always_comb begin
        next_state = IDLE;
        if (scan_req) begin
            next_state = READ;
        end else if (count != '0) begin
            next_state = WRITE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign mem_we = state[0];
    assign mem_re = state[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (next_state)
                READ: begin
                    mem_addr <= scan_addr;
                end
                WRITE: begin
                    mem_addr  <= head_addr;
                    mem_wdata <= fifo_c[rd_ptr];
                end
                default: begin
                end
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x[wr_ptr] <= x;
            fifo_y[wr_ptr] <= y;
            fifo_c[wr_ptr] <= colour;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (reject && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

    assign busy = (count != '0) || mem_we || mem_re;

endmodule

// File: tb/tb_plot_receiver.sv
// Self-checking bench for plot_receiver: directed vector table, corner-case sequences and
// randomized traffic compared against a queue-based reference model.
module tb_plot_receiver;

    localparam int DEPTH = 4;
    localparam int HR    = 160;
    localparam int VR    = 120;

    logic        clk;
    logic        reset;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        ready;
    logic        scan_req;
    logic [14:0] scan_addr;
    logic [14:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  drop_count;
    logic        busy;

    plot_receiver #(
        .FIFO_DEPTH(DEPTH),
        .H_RES     (HR),
        .V_RES     (VR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .ready     (ready),
        .scan_req  (scan_req),
        .scan_addr (scan_addr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .drop_count(drop_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int colour;
    } wr_t;

    typedef struct {
        int plot;
        int x;
        int y;
        int c;
        int scan;
        int saddr;
        int e_we;
        int e_re;
        int e_addr;
        int e_wdata;
        int e_busy;
    } vec_t;

    wr_t  q[$];
    int   m_drop;
    int   m_addr;
    int   m_wdata;
    int   m_we;
    int   m_re;
    int   total;
    int   bad;
    vec_t vecs[7];

    function automatic bit m_in_range(int xx, int yy);
`ifdef PLOT_RECEIVER_CLIP_EN
        return (xx < HR) && (yy < VR);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_drop  = 0;
        m_addr  = 0;
        m_wdata = 0;
        m_we    = 0;
        m_re    = 0;
    endtask

    // One clock edge of the abstract behaviour: read beats write, FIFO capacity DEPTH.
    task automatic model_edge();
        wr_t w;
        bit  accept;
        accept = plot && (q.size() < DEPTH) && m_in_range(int'(x), int'(y));
        if (plot && !accept && m_drop < 255) m_drop++;
        m_we = 0;
        m_re = 0;
        if (scan_req) begin
            m_re   = 1;
            m_addr = int'(scan_addr);
        end else if (q.size() > 0) begin
            w       = q.pop_front();
            m_we    = 1;
            m_addr  = w.addr;
            m_wdata = w.colour;
        end
        if (accept) begin
            w.addr   = (int'(y) * HR + int'(x)) % 32768;
            w.colour = int'(colour);
            q.push_back(w);
        end
    endtask

    task automatic check_model(input string tag);
        check_output({tag, ".mem_we"}, int'(mem_we), m_we);
        check_output({tag, ".mem_re"}, int'(mem_re), m_re);
        check_output({tag, ".mem_addr"}, int'(mem_addr), m_addr);
        check_output({tag, ".mem_wdata"}, int'(mem_wdata), m_wdata);
        check_output({tag, ".ready"}, int'(ready), (q.size() < DEPTH) ? 1 : 0);
        check_output({tag, ".busy"}, int'(busy), (q.size() != 0 || m_we != 0 || m_re != 0) ? 1 : 0);
        check_output({tag, ".drop_count"}, int'(drop_count), m_drop);
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic apply_stimulus(input int p, input int xx, input int yy, input int c,
                                  input int s, input int sa, input string tag);
        plot      = p[0];
        x         = 8'(xx);
        y         = 8'(yy);
        colour    = 3'(c);
        scan_req  = s[0];
        scan_addr = 15'(sa);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic do_reset();
        plot      = 1'b0;
        scan_req  = 1'b0;
        x         = '0;
        y         = '0;
        colour    = '0;
        scan_addr = '0;
        reset     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check_output("reset.mem_we", int'(mem_we), 0);
        check_output("reset.mem_re", int'(mem_re), 0);
        check_output("reset.mem_addr", int'(mem_addr), 0);
        check_output("reset.mem_wdata", int'(mem_wdata), 0);
        check_output("reset.ready", int'(ready), 1);
        check_output("reset.busy", int'(busy), 0);
        check_output("reset.drop_count", int'(drop_count), 0);
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{1, 5, 2, 5, 0, 0, 0, 0, 0, 0, 1};
        vecs[1] = '{0, 0, 0, 0, 0, 0, 1, 0, 325, 5, 1};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 325, 5, 0};
        vecs[3] = '{1, 10, 1, 2, 0, 0, 0, 0, 325, 5, 1};
        vecs[4] = '{0, 0, 0, 0, 1, 100, 0, 1, 100, 5, 1};
        vecs[5] = '{0, 0, 0, 0, 0, 0, 1, 0, 170, 2, 1};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 170, 2, 0};

        // Single plot, then read priority over one queued write.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].plot, vecs[i].x, vecs[i].y, vecs[i].c,
                           vecs[i].scan, vecs[i].saddr, "vec");
            check_output($sformatf("vec%0d.we", i), int'(mem_we), vecs[i].e_we);
            check_output($sformatf("vec%0d.re", i), int'(mem_re), vecs[i].e_re);
            check_output($sformatf("vec%0d.addr", i), int'(mem_addr), vecs[i].e_addr);
            check_output($sformatf("vec%0d.wdata", i), int'(mem_wdata), vecs[i].e_wdata);
            check_output($sformatf("vec%0d.busy", i), int'(busy), vecs[i].e_busy);
        end

        // Overflow while scan starves writes, then in-order drain.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1, i + 1, 1, i + 1, 1, 7, "ovf");
            check_output($sformatf("ovf%0d.ready", i), int'(ready), (i < 3) ? 1 : 0);
            check_output($sformatf("ovf%0d.drop", i), int'(drop_count), (i < 4) ? 0 : i - 3);
        end
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, "drain");
            check_output($sformatf("drain%0d.we", i), int'(mem_we), (i < 4) ? 1 : 0);
            if (i < 4) begin
                check_output($sformatf("drain%0d.addr", i), int'(mem_addr), 161 + i);
                check_output($sformatf("drain%0d.wdata", i), int'(mem_wdata), i + 1);
            end
        end

        // Asynchronous reset with a full queue and a nonzero drop count.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 20 + i, 3, 4, 1, 9, "prerst");
        end
        #2;
        reset = 1'b1;
        #1;
        check_output("midrst.ready", int'(ready), 1);
        check_output("midrst.busy", int'(busy), 0);
        check_output("midrst.drop", int'(drop_count), 0);
        check_output("midrst.re", int'(mem_re), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, "postrst");
            check_output($sformatf("postrst%0d.we", i), int'(mem_we), 0);
        end

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 304; i++) begin
            apply_stimulus(1, i % 200, 5, 1, 1, 3, "sat");
        end
        check_output("sat.drop_count", int'(drop_count), 255);
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(0, 0, 0, 0, 0, 0, "satdrain");
        end
        check_output("sat.hold", int'(drop_count), 255);

        // Coordinate bounds: clipped, or enqueued at a wrapped address.
        do_reset();
`ifdef PLOT_RECEIVER_CLIP_EN
        apply_stimulus(1, 160, 0, 3, 0, 0, "clip");
        apply_stimulus(0, 0, 0, 0, 0, 0, "clip");
        check_output("clip.we", int'(mem_we), 0);
        check_output("clip.drop", int'(drop_count), 1);
        apply_stimulus(1, 159, 119, 7, 0, 0, "clip");
        apply_stimulus(0, 0, 0, 0, 0, 0, "clip");
        check_output("clip.edge_we", int'(mem_we), 1);
        check_output("clip.edge_addr", int'(mem_addr), 19199);
`else
        apply_stimulus(1, 200, 250, 6, 0, 0, "wrap");
        apply_stimulus(0, 0, 0, 0, 0, 0, "wrap");
        check_output("wrap.we", int'(mem_we), 1);
        check_output("wrap.addr", int'(mem_addr), 7432);
        check_output("wrap.drop", int'(drop_count), 0);
`endif

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus(int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 7)),
                           ($urandom_range(0, 2) == 0) ? 1 : 0,
                           int'($urandom_range(0, 32767)),
                           "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
